// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with the architectural HI/LO pair.
//
// Launching mult/multu/div/divu computes the full result straight away into
// pending registers. busy then stays high for a fixed latency, and the
// result is copied into HI/LO when that latency runs out. mthi/mtlo write
// HI or LO directly when the unit is idle.
//
// Parameters
//   MULT_CYCLES  busy length for mult/multu (1..31)
//   DIV_CYCLES   busy length for div/divu  (1..31)
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-low reset
//   start   in   1   one-cycle request to launch op
//   op      in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   a       in   32  multiplicand / dividend / mthi-mtlo source
//   b       in   32  multiplier / divisor
//   busy    out  1   high while a mult/div is in flight
//   done    out  1   one-cycle pulse in the first cycle HI/LO show a new result
//   hi, lo  out  32  architectural HI and LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic [31:0] pend_hi, pend_hi_next;
  logic [31:0] pend_lo, pend_lo_next;
  logic [31:0] hi_next, lo_next;
  logic        done_next;

  // Result datapath, evaluated from the live operands. Its output is only
  // captured into the pending registers on the accepting edge, so later
  // operand changes cannot disturb an operation in flight.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic [31:0] mag_a, mag_b;
  logic [31:0] uq, ur;
  logic [31:0] sq, sr;
  logic [31:0] dq, dr;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero, div_overflow;

  // Signed division is done on magnitudes, then the quotient takes the XOR
  // of the operand signs (truncation toward zero) and the remainder takes
  // the dividend's sign. A zero divisor is steered to a safe divide of 1
  // and the dedicated zero-divisor result overrides whatever comes out.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};

    div_by_zero  = (b == 32'd0);
    div_overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    if (div_by_zero) begin
      mag_b = 32'd1;
    end
    uq = mag_a / mag_b;
    ur = mag_a % mag_b;
    sq = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    sr = a[31] ? (~ur + 32'd1) : ur;

    dq = a / (div_by_zero ? 32'd1 : b);
    dr = a % (div_by_zero ? 32'd1 : b);

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_by_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_overflow) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (div_by_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = dr;
          res_lo = dq;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Next-state logic. Only IDLE looks at start, so any request made while
  // an operation is in flight (including mthi/mtlo) is dropped without a
  // trace. MUL and DIV differ only in the latency loaded on entry; both
  // count down and retire the pending result on the cnt==1 edge, which
  // leaves the FSM in IDLE so the done cycle can already accept a new start.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    hi_next      = hi;
    lo_next      = lo;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_next   = MUL;
              cnt_next     = 5'(MULT_CYCLES);
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
            end
            OP_DIV, OP_DIVU: begin
              state_next   = DIV;
              cnt_next     = 5'(DIV_CYCLES);
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: begin
            end
          endcase
        end
      end
      MUL, DIV: begin
        if (cnt == 5'd1) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  // State and register file. Reset clears everything including the pending
  // result, so an aborted operation can never surface in HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      hi      <= hi_next;
      lo      <= lo_next;
      done    <= done_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl.
// A table of directed vectors, hand-written sequences for the multi-cycle
// corner cases (ignored requests, back-to-back issue, reset abort), and a
// randomized run checked against a plain-arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mdu_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string tag, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %h, expected %h", tag, what, act, exp);
    end
  endtask

  // Reference model: results derived from the arithmetic rules with 64-bit
  // integers, special cases first.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint          sx, sy, p, q, r;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      3'd0: begin
        p  = sx * sy;
        rh = p[63:32];
        rl = p[31:0];
      end
      3'd1: begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32];
        rl = up[31:0];
      end
      3'd2: begin
        if (y == 32'd0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rh = 32'd0;
          rl = 32'h8000_0000;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          rh = r[31:0];
          rl = q[31:0];
        end
      end
      3'd3: begin
        if (y == 32'd0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else begin
          rh = x % y;
          rl = x / y;
        end
      end
      default: begin
      end
    endcase
  endfunction

  // Drives a one-cycle start from the current point (always #1 after an
  // edge) and scrambles the operands afterwards to prove they were captured.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts busy cycles (bounded), checking that HI/LO hold and done stays low
  // meanwhile, then checks the completion cycle. With tail set, one more
  // cycle is stepped to confirm the done pulse is a single cycle wide.
  task automatic wait_done(input string tag, input int exp_n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input bit tail);
    int          n;
    logic [31:0] old_hi, old_lo;
    old_hi = hi;
    old_lo = lo;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      check_output(tag, "done_while_busy", {31'b0, done}, 32'd0);
      check_output(tag, "hi_hold", hi, old_hi);
      check_output(tag, "lo_hold", lo, old_lo);
      n++;
      @(posedge clk);
      #1;
    end
    check_output(tag, "busy_cycles", n, exp_n);
    check_output(tag, "done_pulse", {31'b0, done}, 32'd1);
    check_output(tag, "hi", hi, exp_hi);
    check_output(tag, "lo", lo, exp_lo);
    if (tail) begin
      @(posedge clk);
      #1;
      check_output(tag, "done_width", {31'b0, done}, 32'd0);
      check_output(tag, "busy_after", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_busy);
    apply_stimulus(o, x, y);
    if (exp_busy > 0) begin
      wait_done(tag, exp_busy, exp_hi, exp_lo, 1'b1);
    end else begin
      check_output(tag, "busy", {31'b0, busy}, 32'd0);
      check_output(tag, "done", {31'b0, done}, 32'd0);
      check_output(tag, "hi", hi, exp_hi);
      check_output(tag, "lo", lo, exp_lo);
    end
  endtask

  initial begin
    logic [31:0] m_hi, m_lo, rh, rl, x, y, old_hi, old_lo;
    logic [2:0]  o;
    int          n;

    checks = 0;
    errors = 0;
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    b      = 32'd0;

    vecs[0] = '{"mult_neg",  3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
    vecs[1] = '{"multu",     3'd1, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, MULT_N};
    vecs[2] = '{"div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[3] = '{"divu_zero", 3'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, DIV_N};
    vecs[4] = '{"div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
    vecs[5] = '{"mthi",      3'd4, 32'h1234_5678, 32'd9,         32'h1234_5678, 32'h8000_0000, 0};
    vecs[6] = '{"mtlo",      3'd5, 32'h0000_ABCD, 32'd9,         32'h1234_5678, 32'h0000_ABCD, 0};
    vecs[7] = '{"reserved",  3'd6, 32'hDEAD_BEEF, 32'd1,         32'h1234_5678, 32'h0000_ABCD, 0};
    vecs[8] = '{"divu",      3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DIV_N};
    vecs[9] = '{"div_negb",  3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};

    // Reset is asynchronous: outputs must be clear before any clock edge.
    reset = 1'b0;
    #2;
    check_output("reset", "busy", {31'b0, busy}, 32'd0);
    check_output("reset", "done", {31'b0, done}, 32'd0);
    check_output("reset", "hi", hi, 32'd0);
    check_output("reset", "lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy);
    end

    // mtlo and mult issued during a div are dropped; a mult in the done
    // cycle is accepted back-to-back.
    $display("[TB] ignored requests and back-to-back issue");
    apply_stimulus(3'd2, 32'd100, 32'd7);
    old_hi = hi;
    old_lo = lo;
    start = 1'b1;
    op    = 3'd5;
    a     = 32'd5;
    @(posedge clk);
    #1;
    check_output("busy_mtlo", "lo", lo, old_lo);
    check_output("busy_mtlo", "busy", {31'b0, busy}, 32'd1);
    op = 3'd0;
    a  = 32'd9;
    b  = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("busy_mult", "hi", hi, old_hi);
    wait_done("div_after_ignored", DIV_N - 2, 32'd2, 32'd14, 1'b0);
    apply_stimulus(3'd0, 32'd3, 32'd4);
    wait_done("b2b_mult", MULT_N, 32'd0, 32'd12, 1'b1);

    // Reset in the third busy cycle of a mult aborts it for good.
    $display("[TB] reset abort");
    run_op("preload_hi", 3'd4, 32'hAAAA_5555, 32'd0, 32'hAAAA_5555, 32'd12, 0);
    apply_stimulus(3'd0, 32'd1000, 32'd1000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_abort", "busy", {31'b0, busy}, 32'd0);
    check_output("rst_abort", "hi", hi, 32'd0);
    check_output("rst_abort", "lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) n++;
    end
    check_output("rst_abort", "late_result_cycles", n, 32'd0);
    run_op("post_reset_mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, MULT_N);

    // Randomized operations against the reference model.
    $display("[TB] random operations");
    m_hi = hi;
    m_lo = lo;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin
          x = 32'h8000_0000;
          y = 32'hFFFF_FFFF;
        end
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      if (o <= 3'd3) begin
        ref_md(o, x, y, rh, rl);
        m_hi = rh;
        m_lo = rl;
        run_op("rand_md", o, x, y, m_hi, m_lo, (o <= 3'd1) ? MULT_N : DIV_N);
      end else begin
        if (o == 3'd4) m_hi = x;
        if (o == 3'd5) m_lo = x;
        run_op("rand_mt", o, x, y, m_hi, m_lo, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
